// File: rtl/iod_delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// iod_delay_line_ctrl
//
// Purpose:
//   Sequences the MOVE / DIRECTION / LOAD controls of an IOD delay line in
//   response to simple step requests.
//   - An increment or decrement request issues REQ_COUNT one-cycle MOVE pulses.
//     Each pulse is followed by MOVE_GAP idle cycles.
//   - A load request issues one LOAD pulse followed by MOVE_GAP idle cycles.
//   - Every accepted request ends with a single-cycle DONE pulse. ERR and
//     STEPS_DONE qualify that pulse.
//   - A range flag raised by the delay line during any gap cycle aborts the
//     request with ERR=1.
//
// Optional feature (macro IOD_DLY_TAP_TRACK_EN):
//   defined   : TAP_POS tracks the tap (+1/-1 per MOVE, LOAD_VAL on LOAD).
//               A pulse that would leave 0..MAX_TAP is never issued; the
//               request then finishes with ERR=1.
//   undefined : TAP_POS is tied to 0 and no bound check is made.
//
// Parameters:
//   TAP_W    width of tap count, tap position and step counters
//   MOVE_GAP idle cycles after each MOVE/LOAD pulse (1..15)
//   LOAD_VAL tap position after a LOAD
//   MAX_TAP  highest legal tap position
//
// Ports:
//   FAB_CLK                 in   sole clock, rising edge
//   SYNC_RST                in   synchronous active-high reset
//   REQ_VALID / REQ_READY   in/out request handshake (READY only in IDLE)
//   REQ_OP                  in   00 inc, 01 dec, 10 load, 11 reserved
//   REQ_COUNT               in   number of steps for inc/dec
//   DONE                    out  one-cycle completion pulse
//   ERR                     out  error qualifier, valid with DONE
//   STEPS_DONE              out  MOVE pulses issued for the request
//   DELAY_LINE_MOVE         out  step pulse to the delay line
//   DELAY_LINE_DIRECTION    out  1 = increment, 0 = decrement
//   DELAY_LINE_LOAD         out  load pulse to the delay line
//   DELAY_LINE_OUT_OF_RANGE in   delay-line range flag (FAB_CLK domain)
//   TAP_POS                 out  tracked tap position
// -----------------------------------------------------------------------------
module iod_delay_line_ctrl #(
    parameter int unsigned TAP_W    = 8,
    parameter int unsigned MOVE_GAP = 4,
    parameter int unsigned LOAD_VAL = 1,
    parameter int unsigned MAX_TAP  = 127
) (
    input  logic             FAB_CLK,
    input  logic             SYNC_RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_OP,
    input  logic [TAP_W-1:0] REQ_COUNT,
    output logic             DONE,
    output logic             ERR,
    output logic [TAP_W-1:0] STEPS_DONE,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic [TAP_W-1:0] TAP_POS
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_LDP   = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    // The gap counter is loaded with MOVE_GAP-1 and runs down to 0, so a
    // gap spans exactly MOVE_GAP cycles.
    localparam logic [3:0] GAP_LAST = 4'(MOVE_GAP - 1);

    logic [2:0]       state_q;
    logic [2:0]       state_nxt;
    logic             err_nxt;
    logic [TAP_W-1:0] cnt_q;
    logic [TAP_W-1:0] step_cnt_q;
    logic [3:0]       gap_cnt_q;
    logic             ld_gap_q;
    logic             dir_q;
    logic             accept;
    logic             pulse_ok;

    assign REQ_READY            = (state_q == ST_IDLE) && !SYNC_RST;
    assign accept               = REQ_VALID && REQ_READY;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign STEPS_DONE           = step_cnt_q;

`ifdef IOD_DLY_TAP_TRACK_EN
    localparam logic [TAP_W-1:0] LOAD_TAP = TAP_W'(LOAD_VAL);
    localparam logic [TAP_W-1:0] MAX_TAP_V = TAP_W'(MAX_TAP);

    logic [TAP_W-1:0] tap_q;

    // A pulse may only be issued if the tap stays within 0..MAX_TAP after it.
    assign pulse_ok = dir_q ? (tap_q < MAX_TAP_V) : (tap_q != '0);
    assign TAP_POS  = tap_q;

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            tap_q <= LOAD_TAP;
        end else if (state_q == ST_PULSE) begin
            tap_q <= dir_q ? (tap_q + 1'b1) : (tap_q - 1'b1);
        end else if ((state_q == ST_LDP) && !ld_gap_q) begin
            tap_q <= LOAD_TAP;
        end
    end
`else
    assign pulse_ok = 1'b1;
    assign TAP_POS  = '0;
`endif

    // Next-state logic. err_nxt is only ever raised on a transition into
    // FIN, so it can feed ERR directly.
    always_comb begin
        state_nxt = state_q;
        err_nxt   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (REQ_OP)
                        OP_INC, OP_DEC: begin
                            if (REQ_COUNT == '0) begin
                                state_nxt = ST_FIN;
                            end else begin
                                state_nxt = ST_SETUP;
                            end
                        end
                        OP_LOAD: state_nxt = ST_LDP;
                        default: begin
                            state_nxt = ST_FIN;
                            err_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            ST_SETUP: begin
                if (pulse_ok) begin
                    state_nxt = ST_PULSE;
                end else begin
                    state_nxt = ST_FIN;
                    err_nxt   = 1'b1;
                end
            end
            ST_PULSE: state_nxt = ST_GAP;
            ST_GAP: begin
                if (DELAY_LINE_OUT_OF_RANGE) begin
                    state_nxt = ST_FIN;
                    err_nxt   = 1'b1;
                end else if (gap_cnt_q == 4'd0) begin
                    if (step_cnt_q == cnt_q) begin
                        state_nxt = ST_FIN;
                    end else if (!pulse_ok) begin
                        state_nxt = ST_FIN;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_PULSE;
                    end
                end
            end
            ST_LDP: begin
                // First LDP cycle carries the LOAD pulse; the rest is the gap.
                if (ld_gap_q) begin
                    if (DELAY_LINE_OUT_OF_RANGE) begin
                        state_nxt = ST_FIN;
                        err_nxt   = 1'b1;
                    end else if (gap_cnt_q == 4'd0) begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the delay-line controls
    // come straight from flops and line up with the state they belong to.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state_q         <= ST_IDLE;
            DELAY_LINE_MOVE <= 1'b0;
            DELAY_LINE_LOAD <= 1'b0;
            DONE            <= 1'b0;
            ERR             <= 1'b0;
            dir_q           <= 1'b0;
            cnt_q           <= '0;
            step_cnt_q      <= '0;
            gap_cnt_q       <= 4'd0;
            ld_gap_q        <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            DELAY_LINE_MOVE <= (state_nxt == ST_PULSE);
            DELAY_LINE_LOAD <= (state_nxt == ST_LDP) && (state_q != ST_LDP);
            DONE            <= (state_nxt == ST_FIN);
            ERR             <= err_nxt;

            if (accept) begin
                cnt_q      <= REQ_COUNT;
                step_cnt_q <= '0;
                ld_gap_q   <= 1'b0;
            end

            // Direction is set up one cycle ahead of the first pulse and
            // held through FIN.
            if ((state_q == ST_IDLE) && (state_nxt == ST_SETUP)) begin
                dir_q <= (REQ_OP == OP_INC);
            end else if (state_q == ST_FIN) begin
                dir_q <= 1'b0;
            end

            case (state_q)
                ST_PULSE: begin
                    step_cnt_q <= step_cnt_q + 1'b1;
                    gap_cnt_q  <= GAP_LAST;
                end
                ST_GAP: begin
                    if (gap_cnt_q != 4'd0) begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                ST_LDP: begin
                    if (!ld_gap_q) begin
                        ld_gap_q  <= 1'b1;
                        gap_cnt_q <= GAP_LAST;
                    end else if (gap_cnt_q != 4'd0) begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iod_delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iod_delay_line_ctrl
//
// Directed bench for iod_delay_line_ctrl with hand-computed expectations.
// Cycle k after acceptance is the state seen after the k-th rising edge,
// counting the accepting edge as k=1.
// -----------------------------------------------------------------------------
module tb_iod_delay_line_ctrl;

    localparam int TAP_W    = 8;
    localparam int MOVE_GAP = 4;
    localparam int LOAD_VAL = 1;
    localparam int MAX_TAP  = 127;

`ifdef IOD_DLY_TAP_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic             FAB_CLK = 1'b0;
    logic             SYNC_RST;
    logic             REQ_VALID;
    logic             REQ_READY;
    logic [1:0]       REQ_OP;
    logic [TAP_W-1:0] REQ_COUNT;
    logic             DONE;
    logic             ERR;
    logic [TAP_W-1:0] STEPS_DONE;
    logic             DELAY_LINE_MOVE;
    logic             DELAY_LINE_DIRECTION;
    logic             DELAY_LINE_LOAD;
    logic             DELAY_LINE_OUT_OF_RANGE;
    logic [TAP_W-1:0] TAP_POS;

    iod_delay_line_ctrl #(
        .TAP_W    (TAP_W),
        .MOVE_GAP (MOVE_GAP),
        .LOAD_VAL (LOAD_VAL),
        .MAX_TAP  (MAX_TAP)
    ) dut (
        .FAB_CLK                 (FAB_CLK),
        .SYNC_RST                (SYNC_RST),
        .REQ_VALID               (REQ_VALID),
        .REQ_READY               (REQ_READY),
        .REQ_OP                  (REQ_OP),
        .REQ_COUNT               (REQ_COUNT),
        .DONE                    (DONE),
        .ERR                     (ERR),
        .STEPS_DONE              (STEPS_DONE),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
        .TAP_POS                 (TAP_POS)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int n_chk = 0;
    int n_err = 0;

    // Per-request observations
    int         done_cyc;
    int         n_load;
    int         load_cyc;
    int         viol;
    int         move_cyc[$];
    logic       err_s;
    logic       dir_s;
    logic [7:0] steps_s;
    logic [7:0] tap_s;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] tap_exp(input int v);
        return TRACK ? 32'(v) : 32'd0;
    endfunction

    function automatic logic [31:0] mv(input int i);
        return (move_cyc.size() > i) ? 32'(move_cyc[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 50 && !REQ_READY; i++) begin
            @(posedge FAB_CLK); #1;
        end
        chk(tag, 32'(REQ_READY), 32'd1);
    endtask

    // Issue one request and trace it until DONE or until the cycle limit.
    // OUT_OF_RANGE is held high during cycle oor_at (sampled at the next edge).
    task automatic run_req(input string tag, input logic [1:0] op, input logic [7:0] cnt,
                           input int oor_at, input int limit);
        logic prev;
        prev = 1'b0;
        wait_ready(tag);
        REQ_OP    = op;
        REQ_COUNT = cnt;
        REQ_VALID = 1'b1;
        done_cyc  = -1;
        n_load    = 0;
        load_cyc  = -1;
        viol      = 0;
        move_cyc.delete();
        err_s     = 1'b0;
        dir_s     = 1'b0;
        steps_s   = 8'd0;
        tap_s     = 8'd0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge FAB_CLK); #1;
            if (k == 1) begin
                // Scramble the request fields: the DUT must use its latched copy.
                REQ_VALID = 1'b0;
                REQ_OP    = ~op;
                REQ_COUNT = 8'hFF;
                dir_s     = DELAY_LINE_DIRECTION;
            end
            if (DELAY_LINE_MOVE) move_cyc.push_back(k);
            if (DELAY_LINE_LOAD) begin
                n_load++;
                load_cyc = k;
            end
            if ((DELAY_LINE_MOVE && DELAY_LINE_LOAD) ||
                (prev && (DELAY_LINE_MOVE || DELAY_LINE_LOAD))) viol++;
            prev = DELAY_LINE_MOVE || DELAY_LINE_LOAD;
            DELAY_LINE_OUT_OF_RANGE = (k == oor_at);
            if (DONE) begin
                done_cyc = k;
                err_s    = ERR;
                steps_s  = STEPS_DONE;
                tap_s    = TAP_POS;
                break;
            end
        end
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
    endtask

    initial begin
        int seen_done;
        SYNC_RST                = 1'b1;
        REQ_VALID               = 1'b0;
        REQ_OP                  = 2'b00;
        REQ_COUNT               = 8'd0;
        DELAY_LINE_OUT_OF_RANGE = 1'b0;

        // Reset state
        repeat (3) @(posedge FAB_CLK);
        #1;
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        chk("rst_move",  32'(DELAY_LINE_MOVE), 32'd0);
        chk("rst_load",  32'(DELAY_LINE_LOAD), 32'd0);
        chk("rst_dir",   32'(DELAY_LINE_DIRECTION), 32'd0);
        chk("rst_done",  32'(DONE), 32'd0);
        chk("rst_err",   32'(ERR), 32'd0);
        chk("rst_steps", 32'(STEPS_DONE), 32'd0);
        chk("rst_tap",   32'(TAP_POS), tap_exp(LOAD_VAL));
        SYNC_RST = 1'b0;
        #1;
        chk("rst_rel_ready", 32'(REQ_READY), 32'd1);

        // Increment by 3: pulses at 2,7,12, DONE at 1+3*5+1 = 17
        run_req("t1_rdy", 2'b00, 8'd3, -1, 100);
        chk("t1_dir",   32'(dir_s), 32'd1);
        chk("t1_mv0",   mv(0), 32'd2);
        chk("t1_mv1",   mv(1), 32'd7);
        chk("t1_mv2",   mv(2), 32'd12);
        chk("t1_nmv",   32'(move_cyc.size()), 32'd3);
        chk("t1_done",  32'(done_cyc), 32'd17);
        chk("t1_err",   32'(err_s), 32'd0);
        chk("t1_steps", 32'(steps_s), 32'd3);
        chk("t1_tap",   32'(tap_s), tap_exp(LOAD_VAL + 3));
        chk("t1_nld",   32'(n_load), 32'd0);
        chk("t1_rule",  32'(viol), 32'd0);

        // Decrement by 5, range flag in the gap after pulse 2 (cycle 9)
        run_req("t2_rdy", 2'b01, 8'd5, 9, 100);
        chk("t2_dir",   32'(dir_s), 32'd0);
        chk("t2_mv0",   mv(0), 32'd2);
        chk("t2_mv1",   mv(1), 32'd7);
        chk("t2_nmv",   32'(move_cyc.size()), 32'd2);
        chk("t2_done",  32'(done_cyc), 32'd10);
        chk("t2_err",   32'(err_s), 32'd1);
        chk("t2_steps", 32'(steps_s), 32'd2);
        chk("t2_tap",   32'(tap_s), tap_exp(LOAD_VAL + 1));

        // Load after moves: LOAD at cycle 1, DONE at 6
        run_req("t3_rdy", 2'b10, 8'd9, -1, 100);
        chk("t3_nld",   32'(n_load), 32'd1);
        chk("t3_ldcyc", 32'(load_cyc), 32'd1);
        chk("t3_nmv",   32'(move_cyc.size()), 32'd0);
        chk("t3_done",  32'(done_cyc), 32'd6);
        chk("t3_err",   32'(err_s), 32'd0);
        chk("t3_tap",   32'(tap_s), tap_exp(LOAD_VAL));
        chk("t3_rule",  32'(viol), 32'd0);

        // Count=0 then reserved op, back to back
        run_req("t4a_rdy", 2'b00, 8'd0, -1, 20);
        chk("t4a_done",  32'(done_cyc), 32'd1);
        chk("t4a_err",   32'(err_s), 32'd0);
        chk("t4a_steps", 32'(steps_s), 32'd0);
        chk("t4a_pulses", 32'(move_cyc.size() + n_load), 32'd0);
        run_req("t4b_rdy", 2'b11, 8'd5, -1, 20);
        chk("t4b_done",  32'(done_cyc), 32'd1);
        chk("t4b_err",   32'(err_s), 32'd1);
        chk("t4b_pulses", 32'(move_cyc.size() + n_load), 32'd0);
        chk("t4b_dir",   32'(dir_s), 32'd0);

        // Reset during the first GAP of a count=4 increment
        seen_done = 0;
        wait_ready("t5_rdy");
        REQ_OP    = 2'b00;
        REQ_COUNT = 8'd4;
        REQ_VALID = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge FAB_CLK); #1;
            if (k == 1) REQ_VALID = 1'b0;
            if (DONE) seen_done++;
        end
        SYNC_RST = 1'b1;
        @(posedge FAB_CLK); #1;
        chk("t5_ready_in_rst", 32'(REQ_READY), 32'd0);
        chk("t5_move",  32'(DELAY_LINE_MOVE), 32'd0);
        chk("t5_dir",   32'(DELAY_LINE_DIRECTION), 32'd0);
        chk("t5_done",  32'(DONE), 32'd0);
        chk("t5_steps", 32'(STEPS_DONE), 32'd0);
        chk("t5_tap",   32'(TAP_POS), tap_exp(LOAD_VAL));
        SYNC_RST = 1'b0;
        #1;
        chk("t5_ready_rel", 32'(REQ_READY), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(posedge FAB_CLK); #1;
            if (DONE || DELAY_LINE_MOVE) seen_done++;
        end
        chk("t5_no_done", 32'(seen_done), 32'd0);
        chk("t5_ready_idle", 32'(REQ_READY), 32'd1);

`ifdef IOD_DLY_TAP_TRACK_EN
        // Walk the tap up to 126, then hit the upper bound
        run_req("t6a_rdy", 2'b00, 8'd125, -1, 700);
        chk("t6a_done", 32'(done_cyc), 32'd627);
        chk("t6a_tap",  32'(tap_s), 32'd126);
        run_req("t6b_rdy", 2'b00, 8'd3, -1, 100);
        chk("t6b_nmv",   32'(move_cyc.size()), 32'd1);
        chk("t6b_done",  32'(done_cyc), 32'd7);
        chk("t6b_err",   32'(err_s), 32'd1);
        chk("t6b_steps", 32'(steps_s), 32'd1);
        chk("t6b_tap",   32'(tap_s), 32'd127);

        // Lower bound: from 1, decrement by 3 stops at 0
        run_req("t7a_rdy", 2'b10, 8'd0, -1, 100);
        chk("t7a_tap",   32'(tap_s), 32'd1);
        run_req("t7b_rdy", 2'b01, 8'd3, -1, 100);
        chk("t7b_nmv",   32'(move_cyc.size()), 32'd1);
        chk("t7b_done",  32'(done_cyc), 32'd7);
        chk("t7b_err",   32'(err_s), 32'd1);
        chk("t7b_tap",   32'(tap_s), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/iod_delay_line_ctrl.md
IOD_DELAY_LINE_CTRL -- requirements
Module: iod_delay_line_ctrl

Interface
REQ-001 Parameter TAP_W, default 8, width of tap count, tap position and step counters.
REQ-002 Parameter MOVE_GAP, default 4, idle cycles after each MOVE or LOAD pulse, valid range 1..15.
REQ-003 Parameter LOAD_VAL, default 1, tap position after a LOAD.
REQ-004 Parameter MAX_TAP, default 127, highest legal tap position.
REQ-005 FAB_CLK  in  1  sole clock; all logic rises on it.
REQ-006 SYNC_RST  in  1  reset; synchronous and active-high.
REQ-007 REQ_VALID  in  1  request present.
REQ-008 REQ_READY  out  1  controller accepts a request.
REQ-009 REQ_OP  in  2  request type: 00 = increment, 01 = decrement, 10 = load, 11 = reserved.
REQ-010 REQ_COUNT  in  TAP_W  number of steps for an increment or decrement.
REQ-011 DONE  out  1  one-cycle completion pulse.
REQ-012 ERR  out  1  error qualifier, valid only while DONE=1.
REQ-013 STEPS_DONE  out  TAP_W  MOVE pulses issued for the last request, valid while DONE=1.
REQ-014 DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD  out  1 each  drive the IOD delay-line controls.
REQ-015 DELAY_LINE_OUT_OF_RANGE  in  1  IOD range flag; treated as synchronous to FAB_CLK.
REQ-016 TAP_POS  out  TAP_W  tracked tap position.

Function
REQ-017 The block SHALL sequence the states IDLE, SETUP, PULSE, GAP, LDP and FIN.
REQ-018 REQ_READY SHALL be 1 only in IDLE; a request is accepted on the cycle where REQ_VALID=1 and REQ_READY=1.
REQ-019 REQ_OP and REQ_COUNT SHALL be latched on acceptance; later changes on those inputs are ignored.
REQ-020 Increment or decrement with count>0: IDLE->SETUP. DIRECTION=1 for increment and 0 for decrement. DIRECTION is driven from SETUP and held until FIN.
REQ-021 SETUP SHALL last 1 cycle, then go to PULSE.
REQ-022 PULSE SHALL assert MOVE for exactly 1 cycle, increment the step counter, then go to GAP.
REQ-023 GAP SHALL last MOVE_GAP cycles. Afterwards, the block goes to PULSE if steps remain, else to FIN.
REQ-024 OUT_OF_RANGE=1 on any GAP or LDP-gap cycle SHALL abort the request: next state FIN with ERR=1.
REQ-025 A request with count=0 SHALL go IDLE->FIN, with DONE 1 cycle after acceptance, ERR=0 and STEPS_DONE=0.
REQ-026 Load: IDLE->LDP. In LDP, LOAD=1 for 1 cycle, then MOVE_GAP gap cycles, then FIN.
REQ-027 Op 11: IDLE->FIN with ERR=1; no delay-line outputs are asserted.
REQ-028 FIN SHALL last exactly 1 cycle with DONE=1, then go to IDLE. REQ_READY=0 in FIN.
REQ-029 MOVE and LOAD SHALL never both be 1 in the same cycle, and SHALL never be 1 on consecutive cycles.
REQ-030 Minimum latency from acceptance to DONE for count=N>0 SHALL be 1+N*(1+MOVE_GAP)+1 cycles.

Reset
REQ-031 SYNC_RST=1 SHALL force, on the next edge: state IDLE; MOVE, LOAD, DIRECTION, DONE and ERR = 0; STEPS_DONE = 0; TAP_POS = LOAD_VAL.
REQ-032 Reset mid-request SHALL abandon the request with no DONE pulse. REQ_READY SHALL be 0 while SYNC_RST=1.

Configuration
REQ-033 Macro IOD_DLY_TAP_TRACK_EN defined: TAP_POS counts +1 or -1 per MOVE and is set to LOAD_VAL on LOAD.
REQ-034 With IOD_DLY_TAP_TRACK_EN defined, a pulse that would take TAP_POS above MAX_TAP or below 0 SHALL NOT be issued. The request goes to FIN with ERR=1.
REQ-035 Macro IOD_DLY_TAP_TRACK_EN undefined: TAP_POS is tied to 0, no bound check is made, and only OUT_OF_RANGE produces a range error.

Verification
REQ-036 Reset, then increment with count=3 and MOVE_GAP=4: MOVE pulses at cycles 2, 7 and 12 after acceptance; DONE at cycle 17; ERR=0; STEPS_DONE=3; TAP_POS=LOAD_VAL+3 (tracking on).
REQ-037 Decrement with count=5, OUT_OF_RANGE raised in the GAP after the 2nd pulse: DONE with ERR=1, STEPS_DONE=2, no 3rd MOVE.
REQ-038 Load after moves: a single 1-cycle LOAD pulse; DONE 6 cycles after acceptance; TAP_POS=1.
REQ-039 Tracking on, TAP_POS=126, increment with count=3: one MOVE, then DONE with ERR=1, STEPS_DONE=1, TAP_POS=127.
REQ-040 SYNC_RST asserted during GAP of a count=4 request: no DONE; all outputs at reset values; REQ_READY=1 on the first cycle after SYNC_RST deasserts.
REQ-041 Count=0 request and op 11 request back-to-back: both give DONE 1 cycle after acceptance, with ERR=0 and ERR=1 respectively, and no MOVE or LOAD.
